// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - widths and types shared by the 4-4-2 inference pipeline
package dnn_pkg;

    localparam int DW    = 5;
    localparam int HW    = 11;
    localparam int OW    = 18;
    localparam int ACC1W = 2 * DW + 2;

    typedef logic signed [DW-1:0]    dnn_data_t;
    typedef logic        [HW-1:0]    hidden_t;
    typedef logic signed [ACC1W-1:0] acc1_t;
    typedef logic signed [OW-1:0]    acc2_t;

endpackage

// File: rtl/dnn_neuron.sv
// rtl/dnn_neuron.sv - combinational 4-input dot product, activation applied by the caller
module dnn_neuron
    import dnn_pkg::*;
#(
    parameter int IW      = DW,
    parameter bit ISIGNED = 1'b1,
    parameter int WW      = DW,
    parameter int AW      = ACC1W
) (
    input  logic [4*IW-1:0]     a_i,
    input  logic [4*WW-1:0]     w_i,
    output logic signed [AW-1:0] acc_o
);

    localparam int PW = IW + WW + 1;

    // One extra bit on the activation lets unsigned inputs share the signed multiplier.
    always_comb begin
        acc_o = '0;
        for (int i = 0; i < 4; i++) begin
            acc_o = acc_o + AW'(PW'(signed'({ISIGNED & a_i[i*IW+IW-1], a_i[i*IW +: IW]}))
                              * PW'(signed'(w_i[i*WW +: WW])));
        end
    end

endmodule

// File: rtl/dnn_top.sv
// rtl/dnn_top.sv - three-stage 4-4-2 feed-forward network (ReLU hidden, step output)
module dnn_top
    import dnn_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] x1,
    input  logic [DW-1:0] x2,
    input  logic [DW-1:0] x3,
    input  logic [DW-1:0] w04, w05, w06, w07,
    input  logic [DW-1:0] w14, w15, w16, w17,
    input  logic [DW-1:0] w24, w25, w26, w27,
    input  logic [DW-1:0] w34, w35, w36, w37,
    input  logic [DW-1:0] w48, w49, w58, w59,
    input  logic [DW-1:0] w68, w69, w78, w79,
    input  logic          in_ready,
    output logic          out0,
    output logic          out1,
    output logic          out0_ready,
    output logic          out1_ready
);

    dnn_data_t x_in  [4];
    dnn_data_t w1_in [4][4];
    dnn_data_t w2_in [4][2];

    assign x_in  = '{x0, x1, x2, x3};
    assign w1_in = '{'{w04, w05, w06, w07}, '{w14, w15, w16, w17},
                     '{w24, w25, w26, w27}, '{w34, w35, w36, w37}};
    assign w2_in = '{'{w48, w49}, '{w58, w59}, '{w68, w69}, '{w78, w79}};

    dnn_data_t x_q  [4];
    dnn_data_t w1_q [4][4];
    dnn_data_t w2_q [4][2];
    logic      valid0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '{default: '0};
            w1_q     <= '{default: '{default: '0}};
            w2_q     <= '{default: '{default: '0}};
            valid0_q <= 1'b0;
        end else begin
            valid0_q <= in_ready;
            if (in_ready) begin
                x_q  <= x_in;
                w1_q <= w1_in;
                w2_q <= w2_in;
            end
        end
    end

    acc1_t   s    [4];
    hidden_t h_d  [4];
    hidden_t h_q  [4];
    dnn_data_t w2s_q [4][2];
    logic    valid1_q;

    for (genvar j = 0; j < 4; j++) begin : g_hidden
        dnn_neuron #(.IW(DW), .ISIGNED(1'b1), .WW(DW), .AW(ACC1W)) u_neuron (
            .a_i   ({x_q[3], x_q[2], x_q[1], x_q[0]}),
            .w_i   ({w1_q[3][j], w1_q[2][j], w1_q[1][j], w1_q[0][j]}),
            .acc_o (s[j])
        );
    end

    // Positive sums never exceed 1024, so the low HW bits hold the ReLU result exactly.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            h_d[j] = s[j][ACC1W-1] ? '0 : s[j][HW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= '{default: '0};
            w2s_q    <= '{default: '{default: '0}};
            valid1_q <= 1'b0;
        end else begin
            h_q      <= h_d;
            w2s_q    <= w2_q;
            valid1_q <= valid0_q;
        end
    end

    acc2_t t [2];
    logic  out0_d, out1_d;
    logic  out0_q, out1_q, ready_q;

    for (genvar k = 0; k < 2; k++) begin : g_output
        dnn_neuron #(.IW(HW), .ISIGNED(1'b0), .WW(DW), .AW(OW)) u_neuron (
            .a_i   ({h_q[3], h_q[2], h_q[1], h_q[0]}),
            .w_i   ({w2s_q[3][k], w2s_q[2][k], w2s_q[1][k], w2s_q[0][k]}),
            .acc_o (t[k])
        );
    end

    assign out0_d = !t[0][OW-1] && (t[0] != '0);
    assign out1_d = !t[1][OW-1] && (t[1] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_q  <= 1'b0;
            out1_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= valid1_q;
            if (valid1_q) begin
                out0_q <= out0_d;
                out1_q <= out1_d;
            end
        end
    end

    assign out0       = out0_q;
    assign out1       = out1_q;
    assign out0_ready = ready_q;
    assign out1_ready = ready_q;

endmodule

// File: tb/tb_dnn_top.sv
// tb/tb_dnn_top.sv - directed and random checks of dnn_top against an arithmetic reference model
module tb_dnn_top;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [4:0] x  [4];
    logic signed [4:0] w1 [4][4];
    logic signed [4:0] w2 [4][2];
    logic in_ready = 1'b0;
    logic out0, out1, out0_ready, out1_ready;

    dnn_top dut (
        .clk(clk), .rst_n(rst_n),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
        .w04(w1[0][0]), .w05(w1[0][1]), .w06(w1[0][2]), .w07(w1[0][3]),
        .w14(w1[1][0]), .w15(w1[1][1]), .w16(w1[1][2]), .w17(w1[1][3]),
        .w24(w1[2][0]), .w25(w1[2][1]), .w26(w1[2][2]), .w27(w1[2][3]),
        .w34(w1[3][0]), .w35(w1[3][1]), .w36(w1[3][2]), .w37(w1[3][3]),
        .w48(w2[0][0]), .w49(w2[0][1]), .w58(w2[1][0]), .w59(w2[1][1]),
        .w68(w2[2][0]), .w69(w2[2][1]), .w78(w2[3][0]), .w79(w2[3][1]),
        .in_ready(in_ready),
        .out0(out0), .out1(out1), .out0_ready(out0_ready), .out1_ready(out1_ready)
    );

    typedef struct {
        int due;
        bit o0;
        bit o1;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_n = 0;
    bit   last0 = 1'b0;
    bit   last1 = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_n, got, exp);
        end
    endtask

    function automatic void model(output bit o0, output bit o1);
        int h[4];
        int s, t;
        for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int i = 0; i < 4; i++) s += int'(x[i]) * int'(w1[i][j]);
            h[j] = (s < 0) ? 0 : s;
        end
        t = 0;
        for (int j = 0; j < 4; j++) t += h[j] * int'(w2[j][0]);
        o0 = (t > 0);
        t = 0;
        for (int j = 0; j < 4; j++) t += h[j] * int'(w2[j][1]);
        o1 = (t > 0);
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < 4; i++) begin
            x[i] = 5'($urandom);
            for (int j = 0; j < 4; j++) w1[i][j] = 5'($urandom);
        end
        for (int j = 0; j < 4; j++) begin
            w2[j][0] = 5'($urandom);
            w2[j][1] = 5'($urandom);
        end
    endtask

    task automatic set_uniform(input int xv, input int w1v, input int w8, input int w9);
        for (int i = 0; i < 4; i++) begin
            x[i] = 5'(xv);
            for (int j = 0; j < 4; j++) w1[i][j] = 5'(w1v);
        end
        for (int j = 0; j < 4; j++) begin
            w2[j][0] = 5'(w8);
            w2[j][1] = 5'(w9);
        end
    endtask

    task automatic check_outs();
        exp_t e;
        bit   er;
        er = 1'b0;
        if (q.size() > 0 && q[0].due == edge_n) begin
            e = q.pop_front();
            last0 = e.o0;
            last1 = e.o1;
            er = 1'b1;
        end
        check_eq("out0_ready", 32'(out0_ready), 32'(er));
        check_eq("out1_ready", 32'(out1_ready), 32'(er));
        check_eq("out0", 32'(out0), 32'(last0));
        check_eq("out1", 32'(out1), 32'(last1));
    endtask

    // Called at a falling edge; presents a sample (or idle) for the next rising edge.
    task automatic drive(input bit v, input bit fixed, input bit f0, input bit f1);
        bit o0, o1;
        in_ready = v;
        if (v) begin
            if (fixed) begin
                o0 = f0;
                o1 = f1;
            end else begin
                model(o0, o1);
            end
            q.push_back('{edge_n + 3, o0, o1});
        end
        @(posedge clk);
        @(negedge clk);
        if (!v) randomize_inputs();
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        randomize_inputs();
        repeat (3) @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        set_uniform(1, 1, 1, 1);       drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle(3);
        set_uniform(1, -1, 1, 1);      drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);
        set_uniform(-16, -16, -16, 15); drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);
        set_uniform(1, 1, 1, -1);      drive(1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);

        set_uniform(-16, -16, -16, 15); drive(1'b1, 1'b1, 1'b0, 1'b1);
        set_uniform(1, 1, 1, -1);      drive(1'b1, 1'b1, 1'b1, 1'b0);
        set_uniform(1, -1, 1, 1);      drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);

        for (int c = 0; c < 300; c++) begin
            randomize_inputs();
            drive(($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0);
        end

        set_uniform(1, 1, 1, 1); drive(1'b1, 1'b0, 1'b0, 1'b0);
        randomize_inputs();      drive(1'b1, 1'b0, 1'b0, 1'b0);
        in_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out0", 32'(out0), 32'd0);
        check_eq("rst_out1", 32'(out1), 32'd0);
        check_eq("rst_out0_ready", 32'(out0_ready), 32'd0);
        check_eq("rst_out1_ready", 32'(out1_ready), 32'd0);
        q.delete();
        last0 = 1'b0;
        last1 = 1'b0;
        repeat (2) @(negedge clk);
        check_outs();
        rst_n = 1'b1;
        idle(4);

        for (int c = 0; c < 100; c++) begin
            randomize_inputs();
            drive(($urandom_range(0, 1) != 0), 1'b0, 1'b0, 1'b0);
        end
        idle(4);
        check_eq("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
